// File: rtl/order_ingress_if.sv
// Order ingress bundle: per-port requester handshakes plus the issued-order bus toward the engine.
interface order_ingress_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            port_enable;
  logic [DATA_WIDTH-1:0]           order_data;
  logic                            order_valid;
  logic [ID_WIDTH-1:0]             grant_id;

  modport master (
    input  req_data, req_valid, port_enable,
    output req_ready, order_data, order_valid, grant_id
  );

  modport slave (
    output req_data, req_valid, port_enable,
    input  req_ready, order_data, order_valid, grant_id
  );
endinterface

// File: rtl/order_ingress_arbiter.sv
// Round-robin arbiter sharing the matching engine's single order port, with an enforced
// inter-order gap, per-port enable mask and a global halt.
module order_ingress_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  order_ingress_if.master      bus,
  input  logic                 halt,
  output logic [CNT_WIDTH-1:0] issued_count,
  output logic                 busy
);
  localparam int ID_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int GAP_WIDTH = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, GAP, HALTED} state_t;

  state_t                 state_reg, state_next;
  logic [ID_WIDTH-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [GAP_WIDTH-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [DATA_WIDTH-1:0]  order_data_reg;
  logic                   order_valid_reg;
  logic [ID_WIDTH-1:0]    grant_id_reg;
  logic [CNT_WIDTH-1:0]   issued_count_reg;

  logic [NUM_PORTS-1:0]   eligible;
  logic                   found;
  logic [ID_WIDTH-1:0]    winner;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  req_words [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign req_words[gi]     = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign bus.req_ready[gi] = accept && (winner == ID_WIDTH'(gi));
    end
  endgenerate

  assign eligible = bus.req_valid & bus.port_enable;

  // First eligible port after the last winner, wrapping; the extra index bit absorbs the wrap.
  always_comb begin : search
    logic [ID_WIDTH:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(k);
      if (idx >= (ID_WIDTH+1)'(NUM_PORTS)) begin
        idx = idx - (ID_WIDTH+1)'(NUM_PORTS);
      end
      if (!found && eligible[idx[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_WIDTH-1:0];
      end
    end
  end

  // rst_n gating keeps req_ready low while the block is held in reset.
  assign accept = rst_n && (state_reg == IDLE) && !halt && found;

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (halt) begin
          state_next = HALTED;
        end else if (found) begin
          rr_ptr_next  = winner;
          gap_cnt_next = GAP_WIDTH'(GAP_CYCLES);
          state_next   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt_reg - GAP_WIDTH'(1);
        if (gap_cnt_reg <= GAP_WIDTH'(1)) begin
          state_next = halt ? HALTED : IDLE;
        end
      end
      HALTED: begin
        if (!halt) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      rr_ptr_reg       <= ID_WIDTH'(NUM_PORTS - 1);
      gap_cnt_reg      <= '0;
      order_valid_reg  <= 1'b0;
      order_data_reg   <= '0;
      grant_id_reg     <= '0;
      issued_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      gap_cnt_reg     <= gap_cnt_next;
      order_valid_reg <= accept;
      if (accept) begin
        order_data_reg   <= req_words[winner];
        grant_id_reg     <= winner;
        issued_count_reg <= issued_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.order_data  = order_data_reg;
  assign bus.order_valid = order_valid_reg;
  assign bus.grant_id    = grant_id_reg;
  assign issued_count    = issued_count_reg;
  assign busy            = (state_reg == GAP);
endmodule

// File: doc/order_ingress_arbiter.md
Name: order_ingress_arbiter

Overview:
- Round-robin arbiter and issue scheduler in front of the order matching engine's single order input port (order_data/order_valid, no backpressure).
- Shares that port between NUM_PORTS order sources (market-feed decoder, TCP order gateway, risk replay, etc.) using per-port valid/ready handshakes.
- Enforces a minimum inter-order gap toward the engine, plus per-port enable masking and a global halt (kill switch).
- Order word format matches the engine: bit 31 is side (1 = buy, 0 = sell), bits 30:0 are price.

Parameters:
- NUM_PORTS, 4, number of requesting sources (2..8).
- DATA_WIDTH, 32, order word width.
- GAP_CYCLES, 1, minimum idle cycles between two issued orders (0 = back-to-back every cycle).
- CNT_WIDTH, 16, width of the issued-order counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_data  in  NUM_PORTS*DATA_WIDTH  packed order words; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  NUM_PORTS  per-port order valid.
- req_ready  out  NUM_PORTS  per-port accept; combinational, one-hot or zero.
- port_enable  in  NUM_PORTS  per-port eligibility mask (0 = port ignored).
- halt  in  1  global stop; blocks new accepts.
- order_data  out  DATA_WIDTH  registered order to the engine.
- order_valid  out  1  one-cycle strobe qualifying order_data.
- grant_id  out  clog2(NUM_PORTS)  index of the port whose order is on order_data.
- issued_count  out  CNT_WIDTH  total orders issued; wraps modulo 2^CNT_WIDTH.
- busy  out  1  high in the GAP state.

Behaviour:
- Reset (async, rst_n low): state=IDLE, order_valid=0, order_data=0, grant_id=0, issued_count=0, busy=0, gap counter=0, RR pointer=NUM_PORTS-1 (so port 0 has first priority). req_ready=0 while in reset.
- Eligible port i: req_valid[i] & port_enable[i].
- FSM states: IDLE, GAP, HALTED.
  - IDLE: if halt, go to HALTED with no accept. Else if any port is eligible, grant the first eligible port searching from RR pointer+1 with wrap. req_ready[g]=1 that cycle and the word is accepted. Then set RR pointer=g, gap counter=GAP_CYCLES, and next state is GAP if GAP_CYCLES>0, else IDLE.
  - GAP: req_ready=0 and the counter decrements each cycle. On the cycle it reaches 1, the next state is HALTED if halt, else IDLE.
  - HALTED: req_ready=0. Return to IDLE on the first cycle halt is low.
- Latency: accept in cycle N gives order_valid=1 in cycle N+1 for exactly one cycle, with order_data=accepted word, grant_id=g, and issued_count incremented in N+1. In all other cycles order_valid=0 and order_data holds its last value.
- Throughput: one order per GAP_CYCLES+1 cycles; with GAP_CYCLES=0, back-to-back accepts every cycle.
- req_ready depends on state, halt, port_enable, req_valid and the RR pointer only; it never depends on order_valid.
- Requesters must hold req_data stable while valid and not ready. The arbiter does not check this.
- A valid dropped before acceptance is simply lost; there is no sticky request.
- Deasserting port_enable while a port is waiting removes it from arbitration immediately (same cycle).
- Halt asserted in the same cycle as a pending request: no accept. Halt never truncates an order already registered; the order_valid pulse still occurs.
- Reset asserted mid-GAP or mid-pulse: outputs clear immediately. Orders in flight are discarded, not replayed.
- issued_count wraps from 2^CNT_WIDTH-1 to 0 without a flag.

Test Plan:
- Single port: after reset, port 0 presents 32'h80000001 at cycle N → req_ready[0]=1 at N; order_valid=1, order_data=32'h80000001, grant_id=0 at N+1; issued_count=1.
- Fairness: all 4 ports held valid continuously (data 32'h8000000i, i = port index), GAP_CYCLES=1 → grant order 0,1,2,3,0…, one issue every 2 cycles, order_valid never high two cycles running; 8 issues yield 2 per port.
- Back-to-back: GAP_CYCLES=0, ports 1 and 3 valid → accepts on consecutive cycles, alternating 1,3,1,3; order_data=32'h00000002 (port 1, sell price 2) and 32'h80000002 (port 3, buy price 2).
- Mask and halt: port_enable=4'b1101 with all valid → port 1 never granted. Assert halt with a request pending → zero accepts while halt is high. Deassert halt → the next grant resumes from RR pointer+1.
- Reset mid-operation: pull rst_n low during GAP → order_valid, issued_count and busy are 0 the same cycle. After release, port 0 wins first.
- Wrap: with CNT_WIDTH=4, issue 17 orders → issued_count reads 1.
